// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO register file for the multiply/divide unit.
// It sequences in-flight multiply/divide operations, accepts MTHI/MTLO writes
// and serves MFHI/MFLO reads with a stall while an operation is in flight.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   IDLE      | nothing in flight; MT writes and MF reads are accepted
//   MULT_BUSY | multiply issued, waiting for mult_done
//   DIV_BUSY  | divide issued, waiting for div_done
module hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic             mult_done,
    input  logic [WIDTH-1:0] mult_hi,
    input  logic [WIDTH-1:0] mult_lo,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_hi,
    input  logic [WIDTH-1:0] div_lo,
    input  logic             div_zero,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic [WIDTH-1:0] mt_data,
    input  logic             mf_req,
    input  logic             mf_sel,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] mf_data,
    output logic             mf_valid,
    output logic             busy,
    output logic             stall,
    output logic             div_zero_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MULT_BUSY = 2'd1,
        DIV_BUSY  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             mult_fin;
    logic             div_fin;
    logic             mf_take;
    logic [WIDTH-1:0] mf_fwd;

    assign busy     = (state != IDLE);
    assign stall    = mf_req & busy;
    assign hi_out   = hi;
    assign lo_out   = lo;
    // Done pulses only count when they belong to the operation in flight.
    assign mult_fin = (state == MULT_BUSY) && mult_done;
    assign div_fin  = (state == DIV_BUSY) && div_done;
    assign mf_take  = mf_req && !busy;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; multiply wins if both starts arrive together.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (mult_start) begin
                    state_nxt = MULT_BUSY;
                end else if (div_start) begin
                    state_nxt = DIV_BUSY;
                end
            end
            MULT_BUSY: begin
                if (mult_done) begin
                    state_nxt = IDLE;
                end
            end
            DIV_BUSY: begin
                if (div_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // HI/LO update: results on completion, MT writes only when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (mult_fin) begin
            hi <= mult_hi;
            lo <= mult_lo;
        end else if (div_fin) begin
            if (!div_zero) begin
                hi <= div_hi;
                lo <= div_lo;
            end
        end else if (!busy) begin
            if (mthi_we) begin
                hi <= mt_data;
            end
            if (mtlo_we) begin
                lo <= mt_data;
            end
        end
    end

    // One-cycle flag when a divide completes with a zero divisor.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_zero_err <= 1'b0;
        end else begin
            div_zero_err <= div_fin && div_zero;
        end
    end

    // Read source: an MT write to the selected register this cycle is
    // forwarded so the reader sees the value HI/LO will hold after the edge.
    always_comb begin
        mf_fwd = lo;
        if (mf_sel) begin
            mf_fwd = mthi_we ? mt_data : hi;
        end else begin
            mf_fwd = mtlo_we ? mt_data : lo;
        end
    end

    // Registered read port; mf_data holds its value between reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mf_data  <= '0;
            mf_valid <= 1'b0;
        end else begin
            mf_valid <= mf_take;
            if (mf_take) begin
                mf_data <= mf_fwd;
            end
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Directed testbench for hilo_unit with hand-computed expectations.
module tb_hilo_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mult_start = 1'b0;
    logic        div_start = 1'b0;
    logic        mult_done = 1'b0;
    logic [31:0] mult_hi = '0;
    logic [31:0] mult_lo = '0;
    logic        div_done = 1'b0;
    logic [31:0] div_hi = '0;
    logic [31:0] div_lo = '0;
    logic        div_zero = 1'b0;
    logic        mthi_we = 1'b0;
    logic        mtlo_we = 1'b0;
    logic [31:0] mt_data = '0;
    logic        mf_req = 1'b0;
    logic        mf_sel = 1'b0;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [31:0] mf_data;
    logic        mf_valid;
    logic        busy;
    logic        stall;
    logic        div_zero_err;

    int checks = 0;
    int failures = 0;

    hilo_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .mult_start   (mult_start),
        .div_start    (div_start),
        .mult_done    (mult_done),
        .mult_hi      (mult_hi),
        .mult_lo      (mult_lo),
        .div_done     (div_done),
        .div_hi       (div_hi),
        .div_lo       (div_lo),
        .div_zero     (div_zero),
        .mthi_we      (mthi_we),
        .mtlo_we      (mtlo_we),
        .mt_data      (mt_data),
        .mf_req       (mf_req),
        .mf_sel       (mf_sel),
        .hi_out       (hi_out),
        .lo_out       (lo_out),
        .mf_data      (mf_data),
        .mf_valid     (mf_valid),
        .busy         (busy),
        .stall        (stall),
        .div_zero_err (div_zero_err)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Step past the next rising edge; inputs are driven and outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Asynchronous reset, checked before any clock edge.
        #2 reset = 1'b1;
        #1;
        chk("rst_hi", hi_out, 32'h0);
        chk("rst_lo", lo_out, 32'h0);
        chk("rst_mf_data", mf_data, 32'h0);
        chk("rst_mf_valid", 32'(mf_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_dz_err", 32'(div_zero_err), 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // Multiply: done three cycles after start.
        mult_start = 1'b1;
        tick();
        mult_start = 1'b0;
        chk("mul_busy0", 32'(busy), 32'h1);
        tick();
        chk("mul_busy1", 32'(busy), 32'h1);
        tick();
        chk("mul_busy2", 32'(busy), 32'h1);
        mult_done = 1'b1;
        mult_hi = 32'h0000_0001;
        mult_lo = 32'hFFFF_FFFE;
        tick();
        mult_done = 1'b0;
        chk("mul_hi", hi_out, 32'h0000_0001);
        chk("mul_lo", lo_out, 32'hFFFF_FFFE);
        chk("mul_busy_end", 32'(busy), 32'h0);

        // MTHI with a coincident MFHI: write-through forwarding.
        mthi_we = 1'b1;
        mt_data = 32'h1234_5678;
        mf_req = 1'b1;
        mf_sel = 1'b1;
        tick();
        mthi_we = 1'b0;
        mf_req = 1'b0;
        chk("fwd_mf_data", mf_data, 32'h1234_5678);
        chk("fwd_mf_valid", 32'(mf_valid), 32'h1);
        chk("fwd_hi", hi_out, 32'h1234_5678);
        tick();
        chk("fwd_valid_drop", 32'(mf_valid), 32'h0);
        chk("fwd_data_hold", mf_data, 32'h1234_5678);

        // Plain MFLO read while idle.
        mf_req = 1'b1;
        mf_sel = 1'b0;
        tick();
        mf_req = 1'b0;
        chk("mflo_data", mf_data, 32'hFFFF_FFFE);
        chk("mflo_valid", 32'(mf_valid), 32'h1);

        // Divide with an MFLO held across the stall.
        div_start = 1'b1;
        tick();
        div_start = 1'b0;
        mf_req = 1'b1;
        mf_sel = 1'b0;
        #1;
        chk("div_stall0", 32'(stall), 32'h1);
        tick();
        chk("div_stall1", 32'(stall), 32'h1);
        chk("div_stall_nv", 32'(mf_valid), 32'h0);
        div_done = 1'b1;
        div_hi = 32'h2;
        div_lo = 32'h7;
        tick();
        div_done = 1'b0;
        chk("div_busy_end", 32'(busy), 32'h0);
        chk("div_stall_end", 32'(stall), 32'h0);
        chk("div_nv_at_idle", 32'(mf_valid), 32'h0);
        chk("div_hi", hi_out, 32'h2);
        chk("div_lo", lo_out, 32'h7);
        tick();
        mf_req = 1'b0;
        chk("div_mf_data", mf_data, 32'h7);
        chk("div_mf_valid", 32'(mf_valid), 32'h1);
        tick();
        chk("div_mf_pulse", 32'(mf_valid), 32'h0);

        // Divide by zero leaves HI/LO alone and flags one cycle.
        mthi_we = 1'b1;
        mt_data = 32'hAAAA_0000;
        tick();
        mthi_we = 1'b0;
        chk("dz_pre_hi", hi_out, 32'hAAAA_0000);
        div_start = 1'b1;
        tick();
        div_start = 1'b0;
        div_done = 1'b1;
        div_zero = 1'b1;
        div_hi = 32'h5;
        div_lo = 32'h6;
        tick();
        div_done = 1'b0;
        div_zero = 1'b0;
        chk("dz_hi", hi_out, 32'hAAAA_0000);
        chk("dz_lo", lo_out, 32'h7);
        chk("dz_err", 32'(div_zero_err), 32'h1);
        chk("dz_busy", 32'(busy), 32'h0);
        tick();
        chk("dz_err_pulse", 32'(div_zero_err), 32'h0);

        // Simultaneous starts: multiply wins, stray div_done and MTHI ignored.
        mult_start = 1'b1;
        div_start = 1'b1;
        tick();
        mult_start = 1'b0;
        div_start = 1'b0;
        div_done = 1'b1;
        div_hi = 32'h99;
        div_lo = 32'h98;
        tick();
        div_done = 1'b0;
        chk("both_busy", 32'(busy), 32'h1);
        chk("both_hi", hi_out, 32'hAAAA_0000);
        mthi_we = 1'b1;
        mt_data = 32'hDEAD_BEEF;
        tick();
        mthi_we = 1'b0;
        chk("busy_mt_hi", hi_out, 32'hAAAA_0000);
        mult_done = 1'b1;
        mult_hi = 32'h3;
        mult_lo = 32'h4;
        tick();
        mult_done = 1'b0;
        chk("both_mul_hi", hi_out, 32'h3);
        chk("both_mul_lo", lo_out, 32'h4);
        chk("both_idle", 32'(busy), 32'h0);
        div_done = 1'b1;
        div_hi = 32'h77;
        tick();
        div_done = 1'b0;
        chk("idle_done_ign", hi_out, 32'h3);

        // MTLO coincident with a start: write lands and FSM moves.
        mtlo_we = 1'b1;
        mt_data = 32'h55;
        div_start = 1'b1;
        tick();
        mtlo_we = 1'b0;
        div_start = 1'b0;
        chk("mt_start_lo", lo_out, 32'h55);
        chk("mt_start_busy", 32'(busy), 32'h1);
        div_done = 1'b1;
        div_hi = 32'h10;
        div_lo = 32'h20;
        tick();
        div_done = 1'b0;
        chk("mt_start_hi", hi_out, 32'h10);
        chk("mt_start_lo2", lo_out, 32'h20);

        // Reset mid-multiply, then a late mult_done is ignored.
        mult_start = 1'b1;
        tick();
        mult_start = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("mrst_busy", 32'(busy), 32'h0);
        chk("mrst_hi", hi_out, 32'h0);
        chk("mrst_lo", lo_out, 32'h0);
        chk("mrst_mf_data", mf_data, 32'h0);
        tick();
        reset = 1'b0;
        mult_done = 1'b1;
        mult_hi = 32'hCAFE;
        mult_lo = 32'hF00D;
        tick();
        mult_done = 1'b0;
        chk("late_hi", hi_out, 32'h0);
        chk("late_lo", lo_out, 32'h0);
        chk("late_busy", 32'(busy), 32'h0);
        chk("late_valid", 32'(mf_valid), 32'h0);
        chk("late_dz", 32'(div_zero_err), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
